// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - attention-core instruction sequencer (load Q/K, execute, drain, normalise, write back)
module inst_sequencer #(
  parameter int col       = 8,
  parameter int drain_cyc = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  num_rows,
  input  logic        mem_valid,
  output logic        mem_ready,
  output logic [21:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int              DW         = $clog2(drain_cyc + 1);
  localparam logic [3:0]      COL_LAST   = 4'(col - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(drain_cyc - 1);

  typedef enum logic [3:0] {
    IDLE, QWR, KWR, KLD, KGAP, EXE, DRAIN, NACC, NDIV, PWR, DONE
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [3:0]    n, n_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic          cnt_at_n;
  logic          cnt_at_col;

  assign cnt_at_n   = (cnt == n - 4'd1);
  assign cnt_at_col = (cnt == COL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      n     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      n     <= n_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    n_nx      = n;
    dcnt_nx   = '0;
    inst      = '0;
    mem_ready = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          n_nx     = num_rows;
          state_nx = (num_rows == 4'd0) ? DONE : QWR;
        end
      end
      QWR: begin
        mem_ready    = 1'b1;
        inst[4]      = mem_valid;
        inst[15:12]  = cnt;
        if (mem_valid) begin
          if (cnt_at_n) begin
            state_nx = KWR;
            cnt_nx   = '0;
          end else cnt_nx = cnt + 4'd1;
        end
      end
      KWR: begin
        mem_ready    = 1'b1;
        inst[2]      = mem_valid;
        inst[15:12]  = cnt;
        if (mem_valid) begin
          if (cnt_at_col) begin
            state_nx = KLD;
            cnt_nx   = '0;
          end else cnt_nx = cnt + 4'd1;
        end
      end
      KLD: begin
        inst[3]     = 1'b1;
        inst[6]     = 1'b1;
        inst[15:12] = cnt;
        if (cnt_at_col) begin
          state_nx = KGAP;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      KGAP: begin
        state_nx = EXE;
        cnt_nx   = '0;
      end
      EXE: begin
        inst[5]     = 1'b1;
        inst[7]     = 1'b1;
        inst[15:12] = cnt;
        if (cnt_at_n) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      // Separate counter so drain length is not capped by the 4-bit cnt.
      DRAIN: begin
        cnt_nx = '0;
        if (dcnt == DRAIN_LAST) state_nx = NACC;
        else dcnt_nx = dcnt + DW'(1);
      end
      NACC: begin
        inst[16] = 1'b1;
        inst[18] = 1'b1;
        if (cnt_at_n) begin
          state_nx = NDIV;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      NDIV: begin
        inst[17] = 1'b1;
        inst[19] = 1'b1;
        if (cnt_at_n) begin
          state_nx = PWR;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      PWR: begin
        inst[16]   = 1'b1;
        inst[0]    = 1'b1;
        inst[11:8] = cnt;
        if (cnt_at_n) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 4'd1;
      end
      DONE: begin
        done     = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - scoreboard bench for inst_sequencer
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_rows;
  logic        mem_valid;
  logic        mem_ready;
  logic [21:0] inst;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;
  logic [24:0] exq[$];

  always #5 clk = ~clk;

  inst_sequencer #(.col(8), .drain_cyc(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .inst(inst),
    .busy(busy), .done(done)
  );

  // Expected word layout: {done, busy, mem_ready, inst[21:0]}
  function automatic logic [24:0] w(input logic d, input logic b, input logic mr, input int i);
    return {d, b, mr, 22'(i)};
  endfunction

  task automatic push_run(input int n, input bit toggle);
    if (n == 0) begin
      exq.push_back(w(1, 1, 0, 0));
      return;
    end
    if (toggle) begin
      exq.push_back(w(0, 1, 1, (1 << 4)));
      exq.push_back(w(0, 1, 1, (1 << 12)));
      exq.push_back(w(0, 1, 1, (1 << 4) | (1 << 12)));
      exq.push_back(w(0, 1, 1, 0));
    end else
      for (int i = 0; i < n; i++) exq.push_back(w(0, 1, 1, (1 << 4) | (i << 12)));
    for (int i = 0; i < 8; i++) exq.push_back(w(0, 1, 1, (1 << 2) | (i << 12)));
    for (int i = 0; i < 8; i++) exq.push_back(w(0, 1, 0, (1 << 3) | (1 << 6) | (i << 12)));
    exq.push_back(w(0, 1, 0, 0));
    for (int i = 0; i < n; i++) exq.push_back(w(0, 1, 0, (1 << 5) | (1 << 7) | (i << 12)));
    for (int i = 0; i < 16; i++) exq.push_back(w(0, 1, 0, 0));
    for (int i = 0; i < n; i++) exq.push_back(w(0, 1, 0, (1 << 16) | (1 << 18)));
    for (int i = 0; i < n; i++) exq.push_back(w(0, 1, 0, (1 << 17) | (1 << 19)));
    for (int i = 0; i < n; i++) exq.push_back(w(0, 1, 0, (1 << 16) | 1 | (i << 8)));
    exq.push_back(w(1, 1, 0, 0));
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; num_rows = 4'd2; mem_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({done, busy, mem_ready, inst} !== 25'h0) begin
      n_mis++;
      $display("FAIL reset_hold got=%h want=%h", {done, busy, mem_ready, inst}, 25'h0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy, mem_ready, inst} !== 25'h0) begin
      n_mis++;
      $display("FAIL reset_release got=%h want=%h", {done, busy, mem_ready, inst}, 25'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_run;
    int j = 0;
    int done_at = -1;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd2; mem_valid = 1'b1;
    push_run(2, 0);
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0; num_rows = 4'd7;
    while (exq.size() > 0) begin
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL full_run cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      if (done && done_at < 0) done_at = j + 1;
      @(posedge clk); #1;
      j++;
    end
    n_cmp++;
    if (done_at !== 44) begin
      n_mis++;
      $display("FAIL full_run_done_cycle got=%0d want=44", done_at);
    end
  endtask

  task automatic test_mem_valid_toggle;
    int j = 0;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd2; mem_valid = 1'b1;
    push_run(2, 1);
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    while (exq.size() > 0) begin
      mem_valid = !(j == 1 || j == 3);
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL valid_toggle cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      @(posedge clk); #1;
      j++;
    end
    mem_valid = 1'b1;
  endtask

  task automatic test_reset_mid_run;
    int j = 0;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd2; mem_valid = 1'b1;
    push_run(2, 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (j < 20) begin
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL pre_abort cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      @(posedge clk); #1;
      j++;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({done, busy, mem_ready, inst} !== 25'h0) begin
      n_mis++;
      $display("FAIL abort_in_exe got=%h want=%h", {done, busy, mem_ready, inst}, 25'h0);
    end
    exq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; num_rows = 4'd3;
    push_run(3, 0);
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    while (exq.size() > 0) begin
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL post_abort cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      @(posedge clk); #1;
      j++;
    end
  endtask

  task automatic test_back_to_back;
    int j = 0;
    int ndone = 0;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd1; mem_valid = 1'b1;
    push_run(1, 0);
    exq.push_back(w(0, 0, 0, 0));
    push_run(1, 0);
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    while (exq.size() > 0) begin
      start = (exq.size() > 1);
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      if (done) ndone++;
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 2) begin
      n_mis++;
      $display("FAIL back_to_back_done_count got=%0d want=2", ndone);
    end
  endtask

  task automatic test_zero_rows;
    int j = 0;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd0; mem_valid = 1'b1;
    push_run(0, 0);
    exq.push_back(w(0, 0, 0, 0));
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    while (exq.size() > 0) begin
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL zero_rows cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      @(posedge clk); #1;
      j++;
    end
  endtask

  task automatic test_max_rows;
    int j = 0;
    logic [24:0] e;
    start = 1'b1; num_rows = 4'd8; mem_valid = 1'b1;
    push_run(8, 0);
    exq.push_back(w(0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0; num_rows = 4'd1;
    while (exq.size() > 0) begin
      @(negedge clk);
      e = exq.pop_front();
      n_cmp++;
      if ({done, busy, mem_ready, inst} !== e) begin
        n_mis++;
        $display("FAIL max_rows cyc=%0d got=%h want=%h", j + 1, {done, busy, mem_ready, inst}, e);
      end
      @(posedge clk); #1;
      j++;
    end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_mem_valid_toggle;
    test_reset_mid_run;
    test_back_to_back;
    test_zero_rows;
    test_max_rows;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter col, default 8, number of kmem rows loaded into the array.
REQ-002 SHALL have parameter drain_cyc, default 16, idle cycles between execute and ofifo readout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins one run when sampled high in IDLE.
REQ-006 SHALL have port num_rows  input  4  number of Q rows per run; legal range 1..8; latched at start.
REQ-007 SHALL have port mem_valid  input  1  external mem_in word present this cycle.
REQ-008 SHALL have port mem_ready  output  1  sequencer accepts mem_in this cycle; high only in QWR/KWR.
REQ-009 SHALL have port inst  output  22  core instruction word.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-012 SHALL drive inst fields as: [0] pmem_wr, [1] pmem_rd, [2] kmem_wr, [3] kmem_rd, [4] qmem_wr, [5] qmem_rd, [6] load, [7] execute, [11:8] pmem_add, [15:12] qkmem_add, [16] ofifo_rd, [17] div, [18] acc, [19] sfp_pmem_wr, [21:20] always 0.
REQ-013 SHALL decode inst, mem_ready, busy and done combinationally from state register, 4-bit counter cnt, latched N and mem_valid only; every field not listed for a state SHALL be 0.
REQ-014 SHALL implement states IDLE, QWR, KWR, KLD, KGAP, EXE, DRAIN, NACC, NDIV, PWR, DONE, in that order.
REQ-015 IDLE: inst=0; start=1 -> latch N=num_rows, cnt=0, go QWR; num_rows=0 -> go directly to DONE.
REQ-016 QWR: mem_ready=1; inst[4]=mem_valid, qkmem_add=cnt; cnt advances only when mem_valid=1; accept at cnt=N-1 -> KWR, cnt=0.
REQ-017 KWR: same handshake with inst[2]; accept at cnt=col-1 -> KLD, cnt=0.
REQ-018 KLD: col cycles, inst[3]=1, inst[6]=1, qkmem_add=cnt; then KGAP.
REQ-019 KGAP: exactly one cycle, inst=0; then EXE.
REQ-020 EXE: N cycles, inst[5]=1, inst[7]=1, qkmem_add=cnt; then DRAIN.
REQ-021 DRAIN: drain_cyc cycles, inst=0; then NACC.
REQ-022 NACC: N cycles, inst[16]=1, inst[18]=1; then NDIV.
REQ-023 NDIV: N cycles, inst[17]=1, inst[19]=1; then PWR.
REQ-024 PWR: N cycles, inst[16]=1, inst[0]=1, pmem_add=cnt; then DONE.
REQ-025 DONE: one cycle, done=1, inst=0; then IDLE.
REQ-026 cnt SHALL reset to 0 on every state entry and SHALL never exceed 15; drain counting SHALL use a separate counter of width clog2(drain_cyc+1).
REQ-027 start while busy SHALL be ignored; num_rows changes after start SHALL have no effect.
REQ-028 mem_valid outside QWR/KWR SHALL be ignored.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, cnt=0, N=0, drain counter=0, inst=0, mem_ready=0, busy=0, done=0, including mid-run.
REQ-030 after reset release, the first start SHALL begin a complete run with no residue from the aborted run.

Verification
REQ-031 num_rows=2, mem_valid=1 constant, drain_cyc=16, start pulse -> qmem_wr addr 0,1; kmem_wr addr 0..7; 8 load cycles; 1 gap; exec addr 0,1; 16 idle; 2 acc; 2 div; pmem_wr addr 0,1; done high in the 44th cycle after the start edge.
REQ-032 mem_valid toggling 1,0,1,0 in QWR with num_rows=2 -> qmem_wr only on valid cycles, addresses 0 then 1, QWR lasts 3 cycles.
REQ-033 reset asserted during EXE -> inst=0, busy=0 the same cycle; a later start runs fully from QWR addr 0.
REQ-034 start held high through a whole run -> exactly one done per run; new run begins the cycle after DONE returns to IDLE.
REQ-035 num_rows=0, start -> no memory writes; done pulses the cycle after start; busy high for that one cycle only.
REQ-036 num_rows=8 -> addresses 0..7 in QWR, EXE and PWR; inst[21:20]=0 in every cycle.
